// File: rtl/ex_pkg.sv
// Shared constants and types for the execute-stage issue/collect controller.
package ex_pkg;

  localparam logic [4:0] OP_OP  = 5'b01100;
  localparam logic [4:0] OP_IMM = 5'b00100;

  localparam int unsigned DEF_ALU_LAT = 1;
  localparam int unsigned DEF_MUL_LAT = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  // Counter width large enough for the longer of the two latencies.
  function automatic int unsigned cnt_width(input int unsigned alu_lat, input int unsigned mul_lat);
    int unsigned m;
    m = (mul_lat > alu_lat) ? mul_lat : alu_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ex_lat_cnt.sv
// Loadable latency down-counter; expire flags the last waiting cycle (cnt==1).
module ex_lat_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue/collect controller: ID handshake in, fixed-latency ALU request, WB handshake out.
// Optional performance counters are enabled with the EX_PERF_CNT_EN macro.
module ex_issue_ctrl
  import ex_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALU_LAT = DEF_ALU_LAT,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [4:0]      id_op,
  input  logic [2:0]      id_fun_3,
  input  logic            id_fun_7,
  input  logic            id_mulbit,
  input  logic [XLEN-1:0] id_operand1,
  input  logic [XLEN-1:0] id_operand2,
  input  logic [4:0]      id_rd,
  output logic [4:0]      alu_op,
  output logic [2:0]      alu_fun_3,
  output logic            alu_fun_7,
  output logic            alu_mulbit,
  output logic [XLEN-1:0] alu_operand1,
  output logic [XLEN-1:0] alu_operand2,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_result,
  output logic [4:0]      wb_rd,
  output logic            busy
`ifdef EX_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_mul_ops
`endif
);

  localparam int unsigned   CW    = cnt_width(ALU_LAT, MUL_LAT);
  localparam logic [CW-1:0] ALU_L = CW'(ALU_LAT);
  localparam logic [CW-1:0] MUL_L = CW'(MUL_LAT);

  state_t    state;
  logic [4:0] rd_q;
  logic       accept;
  logic       is_mul;
  logic       expire;

  assign id_ready = ~rst & ~flush & ((state == IDLE) | ((state == DONE) & wb_ready));
  assign accept   = id_valid & id_ready;
  assign is_mul   = (id_op == OP_OP) & id_mulbit;
  assign busy     = (state != IDLE);

  ex_lat_cnt #(.W(CW)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .load     (accept),
    .dec      (state == WAIT),
    .load_val (is_mul ? MUL_L : ALU_L),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      alu_op       <= '0;
      alu_fun_3    <= '0;
      alu_fun_7    <= 1'b0;
      alu_mulbit   <= 1'b0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      rd_q         <= '0;
      wb_valid     <= 1'b0;
      wb_result    <= '0;
      wb_rd        <= '0;
    end else if (flush) begin
      state    <= IDLE;
      wb_valid <= 1'b0;
    end else begin
      // A retire in DONE and a new accept share one edge, so accept is handled outside the case.
      if (accept) begin
        alu_op       <= id_op;
        alu_fun_3    <= id_fun_3;
        alu_fun_7    <= id_fun_7;
        alu_mulbit   <= id_mulbit;
        alu_operand1 <= id_operand1;
        alu_operand2 <= id_operand2;
        rd_q         <= id_rd;
      end
      case (state)
        IDLE: begin
          if (accept) state <= WAIT;
        end
        WAIT: begin
          if (expire) begin
            wb_result <= alu_result;
            wb_rd     <= rd_q;
            wb_valid  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= accept ? WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EX_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_mul_ops      <= '0;
    end else begin
      if (id_valid && !id_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (accept && is_mul)      perf_mul_ops      <= perf_mul_ops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl with a scoreboard of expected write-back results.
module tb_ex_issue_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, id_valid, id_fun_7, id_mulbit, wb_ready;
  logic            id_ready, alu_fun_7, alu_mulbit, wb_valid, busy;
  logic [4:0]      id_op, id_rd, alu_op, wb_rd;
  logic [2:0]      id_fun_3, alu_fun_3;
  logic [XLEN-1:0] id_operand1, id_operand2, alu_operand1, alu_operand2, alu_result, wb_result;
`ifdef EX_PERF_CNT_EN
  logic [31:0]     perf_stall_cycles, perf_mul_ops;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ex_issue_ctrl #(.XLEN(XLEN), .ALU_LAT(1), .MUL_LAT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_op        (id_op),
    .id_fun_3     (id_fun_3),
    .id_fun_7     (id_fun_7),
    .id_mulbit    (id_mulbit),
    .id_operand1  (id_operand1),
    .id_operand2  (id_operand2),
    .id_rd        (id_rd),
    .alu_op       (alu_op),
    .alu_fun_3    (alu_fun_3),
    .alu_fun_7    (alu_fun_7),
    .alu_mulbit   (alu_mulbit),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_result   (alu_result),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_result    (wb_result),
    .wb_rd        (wb_rd),
    .busy         (busy)
`ifdef EX_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_mul_ops      (perf_mul_ops)
`endif
  );

  // Simple ALU model: OP_OP with mulbit multiplies, OP_OP with fun_7 subtracts, otherwise adds.
  always_comb begin
    alu_result = alu_operand1 + alu_operand2;
    if (alu_op == 5'b01100 && alu_mulbit)     alu_result = alu_operand1 * alu_operand2;
    else if (alu_op == 5'b01100 && alu_fun_7) alu_result = alu_operand1 - alu_operand2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] f3, input logic f7, input logic mb,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] res, input int lat, input bit push);
    id_op = op; id_fun_3 = f3; id_fun_7 = f7; id_mulbit = mb;
    id_operand1 = a; id_operand2 = b; id_rd = rd; id_valid = 1'b1;
    #1;
    chk("id_ready_pre", id_ready, 1);
    step();
    id_valid = 1'b0;
    chk("alu_operand1", alu_operand1, a);
    chk("alu_operand2", alu_operand2, b);
    chk("alu_op", alu_op, op);
    chk("busy_accept", busy, 1);
    if (push) sb.push_back('{res: res, rd: rd, lat: lat});
  endtask

  // Called right after the accept edge; waits (bounded) for wb_valid and checks latency and data.
  task automatic wait_wb();
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!wb_valid && cyc < 20) begin
      chk("id_ready_in_wait", id_ready, 0);
      step();
      cyc++;
    end
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("latency", cyc, e.lat);
      chk("wb_valid", wb_valid, 1);
      chk("wb_result", wb_result, e.res);
      chk("wb_rd", wb_rd, e.rd);
    end
  endtask

  task automatic retire();
    wb_ready = 1'b1;
    step();
    chk("wb_valid_retired", wb_valid, 0);
    chk("busy_retired", busy, 0);
  endtask

  initial begin
    // 1: reset with id_valid high
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1; id_valid = 1'b1;
    id_op = 5'b01100; id_fun_3 = '0; id_fun_7 = 1'b0; id_mulbit = 1'b0;
    id_operand1 = 32'd99; id_operand2 = 32'd1; id_rd = 5'd7;
    step();
    step();
    chk("rst_id_ready", id_ready, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_alu_operand1", alu_operand1, 0);
    chk("rst_busy", busy, 0);
    id_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_id_ready", id_ready, 1);
    chk("post_rst_busy", busy, 0);

    // 2: plain add
    issue(5'b01100, 3'b000, 1'b0, 1'b0, 32'd10, 32'd7, 5'd5, 32'd17, 1, 1'b1);
    wait_wb();
    retire();

    // 3: mul uses the long latency; OP_IMM with mulbit does not
    issue(5'b01100, 3'b000, 1'b0, 1'b1, 32'd5, 32'd4, 5'd6, 32'd20, 4, 1'b1);
    wait_wb();
    retire();
    issue(5'b00100, 3'b000, 1'b0, 1'b1, 32'd5, 32'd4, 5'd8, 32'd9, 1, 1'b1);
    wait_wb();
    retire();

    // 4: back-pressure in DONE, then back-to-back retire+accept
    wb_ready = 1'b0;
    issue(5'b01100, 3'b000, 1'b0, 1'b0, 32'd3, 32'd8, 5'd9, 32'd11, 1, 1'b1);
    wait_wb();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_wb_valid", wb_valid, 1);
      chk("hold_wb_result", wb_result, 32'd11);
      chk("hold_wb_rd", wb_rd, 5'd9);
      chk("hold_id_ready", id_ready, 0);
    end
    wb_ready = 1'b1;
    issue(5'b01100, 3'b000, 1'b1, 1'b0, 32'd100, 32'd1, 5'd2, 32'd99, 1, 1'b1);
    chk("b2b_wb_valid", wb_valid, 0);
    wait_wb();
    retire();

    // 5: flush at cycle 2 of a mul, with a competing request
    issue(5'b01100, 3'b000, 1'b0, 1'b1, 32'd6, 32'd7, 5'd3, 32'd42, 4, 1'b0);
    step();
    flush = 1'b1; id_valid = 1'b1; id_operand1 = 32'd55;
    #1;
    chk("flush_id_ready", id_ready, 0);
    step();
    flush = 1'b0; id_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_wb_valid", wb_valid, 0);
    chk("flush_no_accept", alu_operand1, 32'd6);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("flushed_wb_valid", wb_valid, 0);
    end
    issue(5'b01100, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 5'd4, 32'd3, 1, 1'b1);
    wait_wb();
    retire();

    // 6: asynchronous reset mid-WAIT
    issue(5'b01100, 3'b000, 1'b0, 1'b1, 32'd2, 32'd3, 5'd1, 32'd6, 4, 1'b0);
    step();
`ifdef EX_PERF_CNT_EN
    chk("perf_mul_ops", perf_mul_ops, 3);
    chk("perf_stall_cycles", perf_stall_cycles, 1);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("arst_alu_operand1", alu_operand1, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_id_ready", id_ready, 0);
`ifdef EX_PERF_CNT_EN
    chk("arst_perf_mul_ops", perf_mul_ops, 0);
    chk("arst_perf_stall", perf_stall_cycles, 0);
`endif
    rst = 1'b0;
    step();
    chk("after_arst_id_ready", id_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("after_arst_wb_valid", wb_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
